// File: rtl/maze_pkg.sv
// Shared definitions for the maze walker: direction codes, FSM states and cell values.
package maze_pkg;

  localparam int COORD_W_DEFAULT = 4;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  localparam logic CELL_FREE = 1'b0;
  localparam logic CELL_WALL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_PROBE,
    ST_CHECK,
    ST_BACK,
    ST_DONE,
    ST_FAIL
  } state_t;

endpackage

// File: rtl/maze_dir_stack.sv
// LIFO of 2-bit directions taken on the way forward; popped while backtracking.
module maze_dir_stack #(
  parameter int DEPTH = 256,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   ptr;
  logic [AW-1:0] top_idx;

  assign top_idx = ptr[AW-1:0] - AW'(1);
  assign top     = mem[top_idx];
  assign empty   = (ptr == '0);
  assign full    = (ptr == (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr - 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been pushed.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/maze_walker.sv
// Depth-first rat-in-maze solver driving a single-bit maze memory with one-cycle read latency.
module maze_walker
  import maze_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int GOAL_X  = 15,
  parameter int GOAL_Y  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [COORD_W-1:0] mem_x,
  output logic [COORD_W-1:0] mem_y,
  output logic               mem_din,
  input  logic               mem_dout,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               move_valid,
  output logic [1:0]         move_dir,
  output logic               busy,
  output logic               done,
  output logic               fail
);

  localparam logic [COORD_W-1:0] SX    = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] SY    = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] GX    = COORD_W'(GOAL_X);
  localparam logic [COORD_W-1:0] GY    = COORD_W'(GOAL_Y);
  localparam logic [COORD_W-1:0] MAX_C = '1;

  state_t             state, state_d;
  logic [1:0]         dir, dir_d;
  logic [COORD_W-1:0] cur_x_d, cur_y_d;
  logic               mv_d;
  logic [1:0]         mv_dir_d;
  logic               stk_push, stk_pop, stk_clr;
  logic [1:0]         stk_top, back_dir;
  logic               stk_empty, stk_full;
  logic [COORD_W-1:0] nb_x, nb_y, bk_x, bk_y;
  logic               nb_oob;

  function automatic logic [2*COORD_W-1:0] step_xy(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y,
                                                   input logic [1:0] d);
    logic [COORD_W-1:0] nx, ny;
    nx = x;
    ny = y;
    case (d)
      DIR_RIGHT: nx = x + 1'b1;
      DIR_DOWN:  ny = y + 1'b1;
      DIR_LEFT:  nx = x - 1'b1;
      default:   ny = y - 1'b1;
    endcase
    return {nx, ny};
  endfunction

  function automatic logic edge_hit(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y,
                                    input logic [1:0] d);
    case (d)
      DIR_RIGHT: return x == MAX_C;
      DIR_DOWN:  return y == MAX_C;
      DIR_LEFT:  return x == '0;
      default:   return y == '0;
    endcase
  endfunction

  assign {nb_x, nb_y} = step_xy(cur_x, cur_y, dir);
  assign nb_oob       = edge_hit(cur_x, cur_y, dir);
  // Backtracking retraces the popped move in reverse; that cell was entered from here, so no bound check.
  assign back_dir     = stk_top ^ 2'b10;
  assign {bk_x, bk_y} = step_xy(cur_x, cur_y, back_dir);

  maze_dir_stack #(
    .DEPTH (1 << (2 * COORD_W)),
    .W     (2)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .clear     (stk_clr),
    .push      (stk_push),
    .push_data (dir),
    .pop       (stk_pop),
    .top       (stk_top),
    .empty     (stk_empty),
    .full      (stk_full)
  );

  always_comb begin
    state_d  = state;
    dir_d    = dir;
    cur_x_d  = cur_x;
    cur_y_d  = cur_y;
    mv_d     = 1'b0;
    mv_dir_d = move_dir;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_din  = 1'b0;
    mem_x    = '0;
    mem_y    = '0;
    unique case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          cur_x_d = SX;
          cur_y_d = SY;
          dir_d   = DIR_RIGHT;
          stk_clr = 1'b1;
          state_d = ST_MARK;
        end
      end
      ST_MARK: begin
        mem_wr  = 1'b1;
        mem_din = CELL_WALL;
        mem_x   = cur_x;
        mem_y   = cur_y;
        state_d = (cur_x == GX && cur_y == GY) ? ST_DONE : ST_PROBE;
      end
      ST_PROBE: begin
        if (nb_oob) begin
          if (dir == DIR_UP) state_d = ST_BACK;
          else               dir_d   = dir + 1'b1;
        end else begin
          mem_rd  = 1'b1;
          mem_x   = nb_x;
          mem_y   = nb_y;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (mem_dout == CELL_FREE) begin
          stk_push = !stk_full;
          cur_x_d  = nb_x;
          cur_y_d  = nb_y;
          mv_d     = 1'b1;
          mv_dir_d = dir;
          dir_d    = DIR_RIGHT;
          state_d  = ST_MARK;
        end else if (dir == DIR_UP) begin
          state_d = ST_BACK;
        end else begin
          dir_d   = dir + 1'b1;
          state_d = ST_PROBE;
        end
      end
      ST_BACK: begin
        if (stk_empty) begin
          state_d = ST_FAIL;
        end else begin
          stk_pop  = 1'b1;
          cur_x_d  = bk_x;
          cur_y_d  = bk_y;
          mv_d     = 1'b1;
          mv_dir_d = back_dir;
          if (stk_top != DIR_UP) begin
            dir_d   = stk_top + 1'b1;
            state_d = ST_PROBE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      dir        <= DIR_RIGHT;
      cur_x      <= '0;
      cur_y      <= '0;
      move_valid <= 1'b0;
      move_dir   <= 2'd0;
    end else begin
      state      <= state_d;
      dir        <= dir_d;
      cur_x      <= cur_x_d;
      cur_y      <= cur_y_d;
      move_valid <= mv_d;
      move_dir   <= mv_dir_d;
    end
  end

  assign busy = (state == ST_MARK) || (state == ST_PROBE) ||
                (state == ST_CHECK) || (state == ST_BACK);
  assign done = (state == ST_DONE);
  assign fail = (state == ST_FAIL);

endmodule

// File: tb/tb_maze_walker.sv
// Directed bench for maze_walker with a behavioural 16x16 maze memory and hand-computed walks.
module tb_maze_walker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mem_rd, mem_wr, mem_din, mem_dout;
  logic [3:0] mem_x, mem_y, cur_x, cur_y;
  logic       move_valid, busy, done, fail;
  logic [1:0] move_dir;

  logic       start2 = 1'b0;
  logic       mem_rd2, mem_wr2, mem_din2;
  logic       mem_dout2 = 1'b0;
  logic [3:0] mem_x2, mem_y2, cur_x2, cur_y2;
  logic       move_valid2, busy2, done2, fail2;
  logic [1:0] move_dir2;

  always #5 clk = ~clk;

  maze_walker u_dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_x(mem_x), .mem_y(mem_y),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .cur_x(cur_x), .cur_y(cur_y), .move_valid(move_valid), .move_dir(move_dir),
    .busy(busy), .done(done), .fail(fail)
  );

  maze_walker #(.START_X(5), .START_Y(5), .GOAL_X(5), .GOAL_Y(5)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .mem_rd(mem_rd2), .mem_wr(mem_wr2), .mem_x(mem_x2), .mem_y(mem_y2),
    .mem_din(mem_din2), .mem_dout(mem_dout2),
    .cur_x(cur_x2), .cur_y(cur_y2), .move_valid(move_valid2), .move_dir(move_dir2),
    .busy(busy2), .done(done2), .fail(fail2)
  );

  // Maze memory: fixed walls from the bench plus cells the walker marks.
  logic wall  [16][16];
  logic visit [16][16];
  logic clr_visit = 1'b0;

  always @(posedge clk) begin
    if (clr_visit) begin
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++) visit[i][j] <= 1'b0;
    end else if (mem_wr) begin
      visit[mem_y][mem_x] <= mem_din;
    end
    if (mem_rd) mem_dout <= wall[mem_y][mem_x] | visit[mem_y][mem_x];
  end

  int n_chk = 0;
  int n_err = 0;
  logic log_en = 1'b0;
  int n_mv, busy_cyc, conflicts, rd10;
  int mv_dir [64];
  int mv_x   [64];
  int mv_y   [64];
  int exp_dir [64];
  int wr55 = 0, mv2 = 0, rd2 = 0;

  always @(negedge clk) begin
    if (!log_en) begin
      n_mv = 0; busy_cyc = 0; conflicts = 0; rd10 = 0;
    end else begin
      if (busy) busy_cyc++;
      if (mem_rd && mem_wr) conflicts++;
      if (mem_rd && mem_x == 4'd1 && mem_y == 4'd0) rd10++;
      if (move_valid && n_mv < 64) begin
        mv_dir[n_mv] = int'(move_dir);
        mv_x[n_mv]   = int'(cur_x);
        mv_y[n_mv]   = int'(cur_y);
        n_mv++;
      end
    end
    if (mem_wr2 && mem_din2 && mem_x2 == 4'd5 && mem_y2 == 4'd5) wr55++;
    if (move_valid2) mv2++;
    if (mem_rd2) rd2++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_visit();
    clr_visit = 1'b1;
    @(posedge clk);
    #1 clr_visit = 1'b0;
  endtask

  task automatic clear_walls();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) wall[i][j] = 1'b0;
  endtask

  task automatic run_walk(input string t, input int max_cyc);
    log_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    log_en = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk({t, "_flags_clr"}, 32'(done | fail), 0);
    for (int c = 0; c < max_cyc; c++) begin
      if (!busy) break;
      @(negedge clk);
    end
    #1;
    chk({t, "_walk_ends"}, 32'(busy), 0);
  endtask

  task automatic verify_moves(input string t, input int n_exp);
    int x, y, unmarked;
    x = 0; y = 0; unmarked = 0;
    chk({t, "_nmoves"}, n_mv, n_exp);
    for (int i = 0; i < n_exp; i++) begin
      case (exp_dir[i])
        0: x++;
        1: y++;
        2: x--;
        default: y--;
      endcase
      chk($sformatf("%s_dir%0d", t, i), mv_dir[i], exp_dir[i]);
      chk($sformatf("%s_pos%0d", t, i), mv_x[i] * 256 + mv_y[i], x * 256 + y);
      if (!visit[y][x]) unmarked++;
    end
    chk({t, "_unmarked"}, unmarked, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_walls();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) visit[i][j] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", 32'({done, fail, move_valid}), 0);
    chk("rst_mem", 32'({mem_rd, mem_wr, mem_din, mem_x, mem_y}), 0);
    chk("rst_cur", 32'({cur_x, cur_y, move_dir}), 0);
    rst = 1'b0;

    // Open maze: straight right along row 0, then down column 15.
    run_walk("A", 300);
    chk("A_busy_cyc", busy_cyc, 106);
    chk("A_done", 32'(done), 1);
    chk("A_fail", 32'(fail), 0);
    chk("A_rdwr", conflicts, 0);
    chk("A_cur", 32'({cur_x, cur_y}), 32'hFF);
    for (int i = 0; i < 30; i++) exp_dir[i] = (i < 15) ? 0 : 1;
    verify_moves("A", 30);

    // Wall at (1,0): go down first, then right along row 1, then down.
    clear_visit();
    wall[0][1] = 1'b1;
    run_walk("B", 400);
    chk("B_done", 32'(done), 1);
    chk("B_rd10", rd10, 1);
    for (int i = 0; i < 30; i++) exp_dir[i] = (i == 0) ? 1 : ((i < 16) ? 0 : 1);
    verify_moves("B", 30);

    // Boxed-in start.
    clear_visit();
    wall[1][0] = 1'b1;
    run_walk("C", 100);
    chk("C_fail", 32'(fail), 1);
    chk("C_done", 32'(done), 0);
    chk("C_busy_cyc", busy_cyc, 8);
    chk("C_nmoves", n_mv, 0);

    // Dead-end corridor of length two.
    clear_visit();
    clear_walls();
    wall[0][3] = 1'b1; wall[1][2] = 1'b1; wall[1][1] = 1'b1; wall[1][0] = 1'b1;
    run_walk("D", 200);
    chk("D_fail", 32'(fail), 1);
    chk("D_busy_cyc", busy_cyc, 26);
    chk("D_rdwr", conflicts, 0);
    exp_dir[0] = 0; exp_dir[1] = 0; exp_dir[2] = 2; exp_dir[3] = 2;
    verify_moves("D", 4);

    // Reset mid-walk, then restart into a boxed start: a stale stack would backtrack.
    clear_visit();
    clear_walls();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    chk("E_moving", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("E_rst_busy", 32'({busy, done, fail}), 0);
    chk("E_rst_mem", 32'({mem_rd, mem_wr, mem_din, mem_x, mem_y}), 0);
    chk("E_rst_cur", 32'({cur_x, cur_y, move_valid, move_dir}), 0);
    rst = 1'b0;
    clear_visit();
    wall[0][1] = 1'b1; wall[1][0] = 1'b1;
    run_walk("E", 100);
    chk("E_fail", 32'(fail), 1);
    chk("E_busy_cyc", busy_cyc, 8);
    chk("E_nmoves", n_mv, 0);

    // Start equals goal on the second instance.
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    @(negedge clk);
    chk("F_busy1", 32'({busy2, done2, mem_wr2}), 32'b101);
    @(negedge clk);
    chk("F_done", 32'({busy2, done2, fail2}), 32'b010);
    chk("F_wr55", wr55, 1);
    chk("F_moves", mv2, 0);
    chk("F_reads", rd2, 0);
    chk("F_cur", 32'({cur_x2, cur_y2, move_dir2}), 32'h154);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/maze_walker.md
# maze_walker

Initiator for the 16x16 single-bit maze memory: a depth-first rat-in-maze solver that drives the memory's `rd`/`wr`/`x_pos`/`y_pos`/`data_in` and consumes `data_out`. On `start` it walks from a start cell to a goal cell. It marks every entered cell visited by writing 1, and backtracks through an on-chip direction stack. It reports each move, plus done or fail, to the top-level controller.

## Interface
- `COORD_W`, 4: coordinate width; the maze is 2^COORD_W square.
- `START_X`, 0 / `START_Y`, 0: start cell.
- `GOAL_X`, 15 / `GOAL_Y`, 15: goal cell.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a walk; sampled only in IDLE, DONE or FAIL.
- `mem_rd`  out  1: to memory `rd`.
- `mem_wr`  out  1: to memory `wr`.
- `mem_x`, `mem_y`  out  COORD_W: to memory `x_pos` / `y_pos`.
- `mem_din`  out  1: to memory `data_in`.
- `mem_dout`  in  1: from memory `data_out`; 1 = wall or visited, 0 = free.
- `cur_x`, `cur_y`  out  COORD_W: current rat position.
- `move_valid`  out  1: one-cycle pulse per move.
- `move_dir`  out  2: direction of the move, valid with `move_valid`.
- `busy`  out  1: walk in progress.
- `done`  out  1: goal reached; held until the next accepted start or reset.
- `fail`  out  1: no path exists; held the same way as `done`.

## Operation
- Direction encoding: 0 = right (x+1), 1 = down (y+1), 2 = left (x-1), 3 = up (y-1). The opposite of direction d is d^2.
- States: IDLE, MARK, PROBE, CHECK, BACK, DONE, FAIL.
- IDLE/DONE/FAIL with `start`:
  - cur <= START, dir <= 0, stack cleared, `done`/`fail` cleared.
  - Next state MARK.
- MARK (1 cycle):
  - `mem_wr`=1, `mem_din`=1, address = cur.
  - Next state DONE if cur == GOAL, else PROBE.
- PROBE:
  - If the neighbour in direction dir is out of bounds (wrap never occurs): no memory access. If dir==3 go to BACK, else dir++ and stay in PROBE.
  - Otherwise: `mem_rd`=1, address = neighbour, go to CHECK.
- CHECK: sample `mem_dout`.
  - If 0: push dir, cur <= neighbour, pulse `move_valid` with `move_dir`=dir, dir <= 0, go to MARK.
  - If 1: if dir==3 go to BACK, else dir++ and go to PROBE.
- BACK:
  - If the stack is empty: go to FAIL.
  - Otherwise pop d, cur <= cur moved in direction d^2, pulse `move_valid` with `move_dir`=d^2.
  - If d==3 stay in BACK; else dir <= d+1 and go to PROBE.
- `busy` = state is MARK, PROBE, CHECK or BACK.
- `start` is ignored while `busy`.
- `mem_rd` and `mem_wr` are never high together. Both are 0 in IDLE, DONE and FAIL.
- Start equal to goal: MARK, then DONE, with zero moves.
- The stack cannot overflow: each push enters a newly marked cell, so at most 2^(2·COORD_W)-1 pushes occur.
- `rst` mid-walk: immediate return to IDLE and stack pointer cleared. Memory contents are untouched.

## Timing
- Reset values:
  - `mem_rd`=`mem_wr`=`mem_din`=0, `mem_x`=`mem_y`=0.
  - `cur_x`=`cur_y`=0, `move_valid`=0, `move_dir`=0.
  - `busy`=`done`=`fail`=0, state IDLE.
- `mem_*` are decoded combinationally from state and registers, so they are valid for the whole cycle.
- Memory read latency is one cycle. Address and `rd` are presented in PROBE; `mem_dout` is sampled at the end of CHECK.
- Cycle costs:
  - Per memory-checked direction: 2 cycles.
  - Per out-of-bounds skip: 1 cycle.
  - MARK: 1 cycle.
  - Each BACK step: 1 cycle.
- `move_valid` is high in the cycle following the CHECK or BACK edge that updates cur. `cur_x`/`cur_y` already show the new cell in that cycle.
- `done` or `fail` rises on the same edge on which `busy` falls.

## Structure
- Shared package `maze_pkg`:
  - Direction constants `DIR_RIGHT`, `DIR_DOWN`, `DIR_LEFT`, `DIR_UP`.
  - State encodings.
  - `COORD_W` default.
  - Wall/free bit values.
- Sub-module `maze_dir_stack`:
  - Parameters `DEPTH` = 2^(2·COORD_W) and width 2.
  - Ports: sync `push`/`pop`, `clear`, `top`, `empty`, `full`.
  - Synchronous reset.

## Test plan
- All-zero maze, start (0,0), goal (15,15):
  - 30 moves: 15 right, then 15 down.
  - `busy` high for exactly 106 cycles, then `done`=1, `fail`=0.
  - All cells on the path read back 1.
- Cell (1,0)=1:
  - First move is down to (0,1), then the walk continues to `done`.
  - No read is ever issued for (1,0) after the first probe.
- Cells (1,0)=1 and (0,1)=1:
  - Left and up are skipped out of bounds.
  - Zero moves; `fail`=1 after MARK + 2 + 1 + 2 + 1 + 1 cycles.
- Dead-end corridor: (0,0)→(1,0)→(2,0) open; (3,0)=1, (2,1)=1, (1,1)=1, (0,1)=1.
  - Two forward moves, then backtrack moves dir 2, dir 2 back to (0,0), then `fail`.
- `rst` asserted mid-walk:
  - Next cycle all outputs at reset values.
  - A new `start` restarts from (0,0) with an empty stack.
- START=GOAL=(5,5):
  - One write to (5,5), `done` 2 cycles after start, no `move_valid`.
